sha_digest_reader: RTL and testbench

//  Read-side counterpart to the SHA-256 digest write. After the hash core finishes, this block reads the
//  256-bit digest back out of the shared RAM (16 x 16-bit words at addrToDigest). It packs the words into

---
 rtl/sha_digest_reader.sv | 119 +++++++++++
 tb/tb_sha_digest_reader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sha_digest_reader.sv
// Reads a 256-bit SHA digest out of shared RAM and streams it to the CAN
// transmitter as four 8-byte payloads over a valid/ready handshake.
module sha_digest_reader #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned DIGEST_WORDS = 16,
    parameter int unsigned FRAME_WORDS  = 4,
    parameter int unsigned READ_LAT     = 1,
    parameter logic [10:0] ID_BASE      = 11'h120
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ADDR_W-1:0]             addrToDigest,
    output logic [ADDR_W-1:0]             addr,
    input  logic [DATA_W-1:0]             data,
    output logic                          ramOutEn,
    output logic                          readPhase,
    output logic                          frameValid,
    input  logic                          frameReady,
    output logic [10:0]                   frameId,
    output logic [FRAME_WORDS*DATA_W-1:0] frameData,
    output logic [3:0]                    frameDlc,
    output logic                          frameLast,
    output logic                          busy,
    output logic                          finish
);
    localparam int unsigned WIDX_W  = $clog2(DIGEST_WORDS);
    localparam int unsigned SLOT_W  = $clog2(FRAME_WORDS);
    localparam int unsigned FIDX_W  = WIDX_W - SLOT_W;
    localparam int unsigned NFRAMES = DIGEST_WORDS / FRAME_WORDS;
    localparam int unsigned LAT_W   = $clog2(READ_LAT + 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] WAIT = 3'd2;
    localparam logic [2:0] SEND = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] addrReg;
    logic [WIDX_W-1:0] wordIdx;
    logic [LAT_W-1:0]  latCnt;
    logic [SLOT_W-1:0] slot;
    logic [FIDX_W-1:0] frameIdx;
    logic              lastFrame;
    logic              ownBus;

    assign slot      = wordIdx[SLOT_W-1:0];
    assign frameIdx  = wordIdx[WIDX_W-1:SLOT_W];
    assign lastFrame = (frameIdx == FIDX_W'(NFRAMES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            addrReg   <= '0;
            wordIdx   <= '0;
            latCnt    <= '0;
            frameData <= '0;
            frameId   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base    <= addrToDigest;
                        wordIdx <= '0;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    // Address wraps modulo 2^ADDR_W; no carry leaves the field.
                    addrReg <= base + ADDR_W'(wordIdx);
                    latCnt  <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (latCnt == LAT_W'(READ_LAT - 1)) begin
                        frameData[(FRAME_WORDS - 1 - slot) * DATA_W +: DATA_W] <= data;
                        if (slot == SLOT_W'(FRAME_WORDS - 1)) begin
                            frameId <= ID_BASE + 11'(frameIdx);
                            state   <= SEND;
                        end else begin
                            wordIdx <= wordIdx + 1'b1;
                            state   <= REQ;
                        end
                    end else begin
                        latCnt <= latCnt + 1'b1;
                    end
                end
                SEND: begin
                    if (frameReady) begin
                        if (lastFrame) begin
                            state <= DONE;
                        end else begin
                            wordIdx <= wordIdx + 1'b1;
                            state   <= REQ;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Bus is owned only while reading; SEND releases it so the arbiter can reuse the RAM.
    assign ownBus     = (state == REQ) || (state == WAIT);
    assign addr       = ownBus ? addrReg : 'z;
    assign ramOutEn   = ownBus;
    assign readPhase  = ownBus;
    assign frameValid = (state == SEND);
    assign frameDlc   = (state == SEND) ? 4'd8 : 4'd0;
    assign frameLast  = (state == SEND) && lastFrame;
    assign busy       = (state != IDLE);
    assign finish     = (state == DONE);

endmodule

// File: tb/tb_sha_digest_reader.sv
// Directed + randomized bench for sha_digest_reader at READ_LAT=1 and READ_LAT=2.
module tb_sha_digest_reader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [15:0] mem [0:1023];

    int          sel;
    logic        startS, readyS;
    logic [9:0]  baseS;
    int          total = 0;
    int          bad   = 0;
    int          finCnt = 0;

    wire  [9:0]  addr1, addr2;
    logic [15:0] data1, data2;
    logic        roe1, rp1, fv1, fl1, busy1, fin1;
    logic        roe2, rp2, fv2, fl2, busy2, fin2;
    logic [10:0] id1, id2;
    logic [63:0] fd1, fd2;
    logic [3:0]  dlc1, dlc2;
    logic        start1, start2, ready1, ready2;

    assign start1 = (sel == 0) && startS;
    assign start2 = (sel == 1) && startS;
    assign ready1 = (sel == 0) && readyS;
    assign ready2 = (sel == 1) && readyS;

    assign data1 = mem[addr1];
    always @(posedge clk) data2 <= mem[addr2];

    sha_digest_reader #(.READ_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .addrToDigest(baseS), .addr(addr1),
        .data(data1), .ramOutEn(roe1), .readPhase(rp1), .frameValid(fv1),
        .frameReady(ready1), .frameId(id1), .frameData(fd1), .frameDlc(dlc1),
        .frameLast(fl1), .busy(busy1), .finish(fin1)
    );

    sha_digest_reader #(.READ_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .addrToDigest(baseS), .addr(addr2),
        .data(data2), .ramOutEn(roe2), .readPhase(rp2), .frameValid(fv2),
        .frameReady(ready2), .frameId(id2), .frameData(fd2), .frameDlc(dlc2),
        .frameLast(fl2), .busy(busy2), .finish(fin2)
    );

    logic [9:0]  fAddr;
    logic        fRoe, fRp, fValid, fLast, fBusy, fFin;
    logic [10:0] fId;
    logic [63:0] fData;
    logic [3:0]  fDlc;

    always_comb begin
        fAddr = addr1; fRoe = roe1; fRp = rp1; fValid = fv1; fLast = fl1;
        fBusy = busy1; fFin = fin1; fId = id1; fData = fd1; fDlc = dlc1;
        if (sel == 1) begin
            fAddr = addr2; fRoe = roe2; fRp = rp2; fValid = fv2; fLast = fl2;
            fBusy = busy2; fFin = fin2; fId = id2; fData = fd2; fDlc = dlc2;
        end
    end

    always @(negedge clk) if (fFin) finCnt++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference payload: four consecutive words from base+4k, addresses wrapping at 1024.
    function automatic logic [63:0] expFrame(input int base, input int k);
        logic [63:0] r = '0;
        for (int j = 0; j < 4; j++) r = {r[47:0], mem[(base + 4 * k + j) % 1024]};
        return r;
    endfunction

    task automatic runRead(input int base, input int stall, input bit reStart, input bit chkLat);
        int edges;
        int budget;
        int finStart;
        int lat;
        logic [63:0] exp;
        lat = (sel == 1) ? 2 : 1;
        finStart = finCnt;
        readyS = (stall == 0);
        @(negedge clk);
        baseS  = 10'(base);
        startS = 1'b1;
        @(negedge clk);
        startS = 1'b0;
        edges  = 0;
        check("busyAfterStart", {63'd0, fBusy}, 64'd1);
        for (int k = 0; k < 4; k++) begin
            budget = 0;
            if (reStart && k == 1) begin
                startS = 1'b1;
                baseS  = 10'(base + 100);
            end
            while (!fValid && budget < 200) begin
                @(negedge clk);
                edges++;
                budget++;
            end
            startS = 1'b0;
            check("frameValid", {63'd0, fValid}, 64'd1);
            if (k == 0 && chkLat) check("latency", 64'(edges), 64'(4 * (1 + lat)));
            exp = expFrame(base, k);
            check("frameData", fData, exp);
            check("frameId", 64'(fId), 64'(11'h120 + k));
            check("frameDlc", 64'(fDlc), 64'd8);
            check("frameLast", {63'd0, fLast}, (k == 3) ? 64'd1 : 64'd0);
            check("ramOutEnSend", {63'd0, fRoe}, 64'd0);
            check("readPhaseSend", {63'd0, fRp}, 64'd0);
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check("stallValid", {63'd0, fValid}, 64'd1);
                check("stallData", fData, exp);
                check("stallId", 64'(fId), 64'(11'h120 + k));
                check("stallRoe", {63'd0, fRoe}, 64'd0);
            end
            readyS = 1'b1;
            @(negedge clk);
            if (stall > 0) readyS = 1'b0;
            check("validDropAfterAccept", {63'd0, fValid}, 64'd0);
        end
        check("finishPulse", {63'd0, fFin}, 64'd1);
        readyS = 1'b0;
        @(negedge clk);
        check("finishCount", 64'(finCnt - finStart), 64'd1);
        check("finishLow", {63'd0, fFin}, 64'd0);
        check("busyIdle", {63'd0, fBusy}, 64'd0);
    endtask

    initial begin
        int budget;
        int finStart;
        sel = 0; startS = 1'b0; readyS = 1'b0; baseS = '0; rst = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 16; i++) mem[64 + i] = 16'(i);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state for both instances
        for (int d = 0; d < 2; d++) begin
            sel = d;
            #1;
            check("rstBusy", {63'd0, fBusy}, 64'd0);
            check("rstValid", {63'd0, fValid}, 64'd0);
            check("rstFinish", {63'd0, fFin}, 64'd0);
            check("rstRoe", {63'd0, fRoe}, 64'd0);
            check("rstReadPhase", {63'd0, fRp}, 64'd0);
            check("rstData", fData, 64'd0);
            check("rstId", 64'(fId), 64'd0);
            check("rstDlc", 64'(fDlc), 64'd0);
            check("rstLast", {63'd0, fLast}, 64'd0);
        end
        sel = 0;

        // Basic read-out, then with long back-pressure
        runRead(64, 0, 1'b0, 1'b1);
        check("frame0Const", expFrame(64, 0), 64'h0000_0001_0002_0003);
        runRead(64, 20, 1'b0, 1'b1);
        // Address wrap
        runRead(1020, 0, 1'b0, 1'b1);
        // start re-asserted mid-transfer is ignored
        runRead(200, 0, 1'b1, 1'b0);

        // Reset during WAIT of word 6
        finStart = finCnt;
        readyS = 1'b1;
        @(negedge clk);
        baseS = 10'd300; startS = 1'b1;
        @(negedge clk);
        startS = 1'b0;
        budget = 0;
        while (!(fRoe && fAddr == 10'd306) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check("reachWord6", {63'd0, (fRoe && fAddr == 10'd306)}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abortBusy", {63'd0, fBusy}, 64'd0);
        check("abortRoe", {63'd0, fRoe}, 64'd0);
        check("abortReadPhase", {63'd0, fRp}, 64'd0);
        check("abortValid", {63'd0, fValid}, 64'd0);
        repeat (3) @(negedge clk);
        check("abortNoFinish", 64'(finCnt - finStart), 64'd0);
        runRead(300, 0, 1'b0, 1'b1);

        // Second latency setting, same known data
        sel = 1;
        @(negedge clk);
        runRead(64, 0, 1'b0, 1'b1);
        runRead(1020, 3, 1'b0, 1'b1);

        // Randomized digests, bases and back-pressure on both instances
        for (int it = 0; it < 6; it++) begin
            sel = it % 2;
            for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
            @(negedge clk);
            runRead(int'($urandom_range(0, 1023)), int'($urandom_range(0, 5)), 1'b0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
